// File: rtl/parl_add_acc_pkg.sv
// Shared types and sizing helpers for the parallel-adder row accumulator.
package parl_add_acc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_WAIT = 2'd2
  } issue_st_e;

  function automatic int row_cnt_w(input int rows);
    return (rows > 32'sd1) ? $clog2(rows) : 32'sd1;
  endfunction

  // Summing `rows` values of `sum_w` bits needs clog2(rows) extra bits.
  function automatic int acc_width(input int sum_w, input int rows);
    return sum_w + row_cnt_w(rows);
  endfunction

  localparam int DEF_ROWS  = 32'sd5;
  localparam int ROW_CNT_W = row_cnt_w(DEF_ROWS);

endpackage

// File: rtl/parl_add_acc_chk.sv
// Protocol checker for the window-sum buffer.
module parl_add_acc_chk (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic full
);

  // A slot is reserved when a window opens, so a push can never meet a full buffer.
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/parl_add_acc_fifo.sv
// Shift-style window-sum FIFO; entry 0 is the registered head seen downstream.
module parl_add_acc_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 25,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0][WIDTH-1:0] data_r;
  logic [DEPTH-1:0][WIDTH-1:0] shift_s;
  logic [CNT_W-1:0]            cnt_r;
  logic [CNT_W-1:0]            cnt_nxt_s;
  logic [CNT_W-1:0]            wr_idx_s;
  logic                        valid_r;
  logic                        full_r;
  logic                        pop_ok_s;

  assign pop_ok_s = pop & valid_r;

  for (genvar g = 0; g < DEPTH; g++) begin : g_shift
    if (g < DEPTH - 1) begin : g_mid
      assign shift_s[g] = data_r[g+1];
    end else begin : g_last
      assign shift_s[g] = data_r[g];
    end
  end

  // Next occupancy and write slot, accounting for a coincident pop.
  always_comb begin
    if (pop_ok_s) begin
      wr_idx_s = cnt_r - CNT_W'(1);
    end else begin
      wr_idx_s = cnt_r;
    end
    if (push && !pop_ok_s) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else if (!push && pop_ok_s) begin
      cnt_nxt_s = cnt_r - CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Entry storage: a push lands on the first free slot, a pop shifts toward the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= {(DEPTH*WIDTH){1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_idx_s == CNT_W'(i))) begin
          data_r[i] <= push_data;
        end else if (pop_ok_s) begin
          data_r[i] <= shift_s[i];
        end else begin
          data_r[i] <= data_r[i];
        end
      end
    end
  end

  // Occupancy and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CNT_W{1'b0}};
      valid_r <= 1'b0;
      full_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      valid_r <= (cnt_nxt_s != {CNT_W{1'b0}});
      full_r  <= (cnt_nxt_s == CNT_W'(DEPTH));
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r[0];
  assign full      = full_r;
  assign count     = cnt_r;

endmodule

// File: rtl/parl_add_acc_ctrl.sv
// Row issue sequencer and window accumulator behind the 5-input adder tree.
// Optional perf counters (win_cnt_o, stall_cnt_o) are built when PARL_ADD_ACC_PERF_EN is defined.
module parl_add_acc_ctrl
  import parl_add_acc_pkg::*;
#(
  parameter int SUM_WIDTH     = 22,
  parameter int ROWS          = 5,
  parameter int ADDER_LATENCY = 4,
  parameter int OUT_DEPTH     = 2,
  parameter int ACC_WIDTH     = acc_width(SUM_WIDTH, ROWS)
) (
  input  logic                 parl_add_acc_clk,
  input  logic                 parl_add_acc_rst_b,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 clear_i,
  input  logic [SUM_WIDTH-1:0] row_sum_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ACC_WIDTH-1:0] out_sum_o,
  output logic                 busy_o
`ifdef PARL_ADD_ACC_PERF_EN
  ,
  output logic [15:0]          win_cnt_o,
  output logic [15:0]          stall_cnt_o
`endif
);

  localparam int              RC_W     = row_cnt_w(ROWS);
  localparam int              BUF_W    = $clog2(OUT_DEPTH + 1);
  localparam logic [RC_W-1:0] LAST_ROW = RC_W'(ROWS - 1);
  localparam logic [BUF_W-1:0] DEPTH_V = BUF_W'(OUT_DEPTH);

  issue_st_e                state_r, state_nxt_s;
  logic [RC_W-1:0]          issue_cnt_r, issue_cnt_nxt_s;
  logic [BUF_W-1:0]         reserved_r, reserved_nxt_s;
  logic                     ready_r, ready_nxt_s;
  logic [ADDER_LATENCY-1:0] vpipe_r;
  logic [ACC_WIDTH-1:0]     acc_r;
  logic [ACC_WIDTH-1:0]     push_data_s;
  logic [RC_W-1:0]          acc_cnt_r;
  logic                     accept_s, pop_s, open_s, tap_s, push_s;
  logic                     buf_full_s;
  logic [BUF_W-1:0]         buf_cnt_s;

  assign in_ready_o  = ready_r & ~clear_i;
  assign accept_s    = in_valid_i & in_ready_o;
  assign pop_s       = out_valid_o & out_ready_i;
  assign open_s      = accept_s & (state_r == S_IDLE);
  assign tap_s       = vpipe_r[ADDER_LATENCY-1];
  assign push_s      = tap_s & (acc_cnt_r == LAST_ROW) & ~clear_i;
  assign push_data_s = acc_r + ACC_WIDTH'(row_sum_i);
  assign busy_o      = (|vpipe_r) | (state_r != S_IDLE) | (acc_cnt_r != {RC_W{1'b0}}) | out_valid_o;

  // Issue FSM next state; an abort leaves only already-buffered windows reserved.
  always_comb begin
    state_nxt_s     = state_r;
    issue_cnt_nxt_s = issue_cnt_r;
    reserved_nxt_s  = reserved_r;
    if (clear_i) begin
      state_nxt_s     = S_IDLE;
      issue_cnt_nxt_s = {RC_W{1'b0}};
      reserved_nxt_s  = buf_cnt_s - BUF_W'(pop_s);
    end else begin
      reserved_nxt_s = reserved_r + BUF_W'(open_s) - BUF_W'(pop_s);
      case (state_r)
        S_IDLE, S_FILL: begin
          if (accept_s) begin
            if (issue_cnt_r == LAST_ROW) begin
              issue_cnt_nxt_s = {RC_W{1'b0}};
              state_nxt_s     = (reserved_nxt_s == DEPTH_V) ? S_WAIT : S_IDLE;
            end else begin
              issue_cnt_nxt_s = issue_cnt_r + RC_W'(1);
              state_nxt_s     = S_FILL;
            end
          end else begin
            state_nxt_s = state_r;
          end
        end
        S_WAIT: begin
          if (pop_s) begin
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_WAIT;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
        end
      endcase
    end
    ready_nxt_s = (state_nxt_s == S_FILL) ||
                  ((state_nxt_s == S_IDLE) && (reserved_nxt_s < DEPTH_V));
  end

  // Issue FSM, reservation counter and registered ready.
  always_ff @(posedge parl_add_acc_clk or negedge parl_add_acc_rst_b) begin
    if (!parl_add_acc_rst_b) begin
      state_r     <= S_IDLE;
      issue_cnt_r <= {RC_W{1'b0}};
      reserved_r  <= {BUF_W{1'b0}};
      ready_r     <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      issue_cnt_r <= issue_cnt_nxt_s;
      reserved_r  <= reserved_nxt_s;
      ready_r     <= ready_nxt_s;
    end
  end

  // Valid pipe mirroring the adder tree latency; its tap qualifies row_sum_i.
  always_ff @(posedge parl_add_acc_clk or negedge parl_add_acc_rst_b) begin
    if (!parl_add_acc_rst_b) begin
      vpipe_r <= {ADDER_LATENCY{1'b0}};
    end else if (clear_i) begin
      vpipe_r <= {ADDER_LATENCY{1'b0}};
    end else begin
      vpipe_r[0] <= accept_s;
      for (int i = 1; i < ADDER_LATENCY; i++) begin
        vpipe_r[i] <= vpipe_r[i-1];
      end
    end
  end

  // Window accumulator; the last row's sum bypasses acc_r straight into the buffer.
  always_ff @(posedge parl_add_acc_clk or negedge parl_add_acc_rst_b) begin
    if (!parl_add_acc_rst_b) begin
      acc_r     <= {ACC_WIDTH{1'b0}};
      acc_cnt_r <= {RC_W{1'b0}};
    end else if (clear_i) begin
      acc_r     <= {ACC_WIDTH{1'b0}};
      acc_cnt_r <= {RC_W{1'b0}};
    end else if (tap_s) begin
      if (acc_cnt_r == LAST_ROW) begin
        acc_r     <= {ACC_WIDTH{1'b0}};
        acc_cnt_r <= {RC_W{1'b0}};
      end else begin
        acc_r     <= push_data_s;
        acc_cnt_r <= acc_cnt_r + RC_W'(1);
      end
    end else begin
      acc_r     <= acc_r;
      acc_cnt_r <= acc_cnt_r;
    end
  end

  parl_add_acc_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (ACC_WIDTH),
    .CNT_W (BUF_W)
  ) u_fifo (
    .clk       (parl_add_acc_clk),
    .rst_n     (parl_add_acc_rst_b),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .out_valid (out_valid_o),
    .out_data  (out_sum_o),
    .full      (buf_full_s),
    .count     (buf_cnt_s)
  );

  parl_add_acc_chk u_chk (
    .clk   (parl_add_acc_clk),
    .rst_n (parl_add_acc_rst_b),
    .push  (push_s),
    .full  (buf_full_s)
  );

`ifdef PARL_ADD_ACC_PERF_EN
  logic [15:0] win_cnt_r;
  logic [15:0] stall_cnt_r;

  // Saturating perf counters, restarted together with an aborted window.
  always_ff @(posedge parl_add_acc_clk or negedge parl_add_acc_rst_b) begin
    if (!parl_add_acc_rst_b) begin
      win_cnt_r   <= 16'h0000;
      stall_cnt_r <= 16'h0000;
    end else if (clear_i) begin
      win_cnt_r   <= 16'h0000;
      stall_cnt_r <= 16'h0000;
    end else begin
      if (pop_s && (win_cnt_r != 16'hFFFF)) begin
        win_cnt_r <= win_cnt_r + 16'h0001;
      end else begin
        win_cnt_r <= win_cnt_r;
      end
      if (in_valid_i && !in_ready_o && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'h0001;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign win_cnt_o   = win_cnt_r;
  assign stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_parl_add_acc_ctrl.sv
// Scoreboard bench for parl_add_acc_ctrl: a behavioural adder tree feeds row sums,
// accepted rows build expected window sums that are compared at each output handshake.
module tb_parl_add_acc_ctrl;

  localparam int SW   = 22;
  localparam int AW   = 25;
  localparam int ROWS = 5;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          in_valid;
  logic          in_ready;
  logic          clear;
  logic [SW-1:0] row_sum;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic          busy;
`ifdef PARL_ADD_ACC_PERF_EN
  logic [15:0]   win_cnt;
  logic [15:0]   stall_cnt;
`endif

  logic [SW-1:0] row_val;
  logic [SW-1:0] tree [4];

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  longint        exp_q [$];
  int            ov_cyc_q [$];
  longint        part_sum = 0;
  int            part_n = 0;
  int            stall_seen = 0;
  longint        last_sum = 0;
  int            t0;
  int            s0;

  parl_add_acc_ctrl dut (
    .parl_add_acc_clk   (clk),
    .parl_add_acc_rst_b (rst_b),
    .in_valid_i         (in_valid),
    .in_ready_o         (in_ready),
    .clear_i            (clear),
    .row_sum_i          (row_sum),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .out_sum_o          (out_sum),
    .busy_o             (busy)
`ifdef PARL_ADD_ACC_PERF_EN
    ,
    .win_cnt_o          (win_cnt),
    .stall_cnt_o        (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural adder tree: operands on row_val reappear on row_sum four cycles later.
  always @(posedge clk) begin
    tree[0] <= row_val;
    for (int i = 1; i < 4; i++) tree[i] <= tree[i-1];
  end
  assign row_sum = tree[3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: build expected windows from accepted rows, compare on each pop.
  always @(negedge clk) begin
    if (!rst_b) begin
      exp_q.delete();
      part_sum   = 0;
      part_n     = 0;
      stall_seen = 0;
    end else begin
      if (clear) begin
        part_sum   = 0;
        part_n     = 0;
        stall_seen = 0;
      end else begin
        if (in_valid && in_ready) begin
          part_sum += longint'(row_val);
          part_n++;
          if (part_n == ROWS) begin
            exp_q.push_back(part_sum);
            part_sum = 0;
            part_n   = 0;
          end
        end
        if (in_valid && !in_ready) stall_seen++;
      end
      if (out_valid) ov_cyc_q.push_back(cyc);
      if (out_valid && out_ready) begin
        last_sum = longint'(out_sum);
        if (exp_q.size() == 0) check("unexpected_window", 64'd1, 64'd0);
        else check("window_sum", out_sum, exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_neg(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  // Present one row and hold it until accepted; returns at #1 after the accepting edge.
  task automatic send_row(input logic [SW-1:0] v);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    row_val  = v;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    row_val  = SW'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b     = 1'b0;
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    row_val   = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst_b = 1'b1;
    idle(2);

    // Single window 1..5, latency and single-cycle valid
    ov_cyc_q.delete();
    t0 = cyc;
    for (int i = 1; i <= 5; i++) send_row(SW'(i));
    check("t2_busy", busy, 1);
    wait_neg(t0 + 15);
    check("t2_nvalid", ov_cyc_q.size(), 1);
    check("t2_latency", ov_cyc_q[0], t0 + 9);
    check("t2_sum", last_sum, 15);

    // Ten rows of 7 back to back, no bubble and no stall
    idle(1);
    ov_cyc_q.delete();
    s0 = stall_seen;
    t0 = cyc;
    repeat (10) send_row(SW'(7));
    check("t3_issue_cycles", cyc, t0 + 10);
    wait_neg(t0 + 20);
    check("t3_nvalid", ov_cyc_q.size(), 2);
    check("t3_first", ov_cyc_q[0], t0 + 9);
    check("t3_second", ov_cyc_q[1], t0 + 14);
    check("t3_stalls", stall_seen - s0, 0);

    // Backpressure with a full buffer, then drain in order
    clear = 1'b1;
    idle(1);
    clear     = 1'b0;
    out_ready = 1'b0;
    t0 = cyc;
    fork
      begin
        for (int i = 1; i <= 15; i++) send_row(SW'(i));
      end
      begin
        wait_neg(t0 + 9);
        check("t4_ready_c9", in_ready, 1);
        wait_neg(t0 + 10);
        check("t4_ready_c10", in_ready, 0);
        wait_neg(t0 + 20);
        check("t4_ready_c20", in_ready, 0);
        check("t4_head_valid", out_valid, 1);
        check("t4_head_sum", out_sum, 15);
`ifdef PARL_ADD_ACC_PERF_EN
        check("t4_stall_cnt", stall_cnt, 10);
        check("t4_win_cnt", win_cnt, 0);
`endif
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(20);
    check("t4_drained", exp_q.size(), 0);
    check("t4_last_sum", last_sum, 65);
    check("t4_busy", busy, 0);
`ifdef PARL_ADD_ACC_PERF_EN
    check("t4_win_total", win_cnt, 3);
`endif

    // Abort a partial window while a completed one sits in the buffer
    out_ready = 1'b0;
    for (int i = 10; i <= 14; i++) send_row(SW'(i));
    idle(8);
    check("t5_buffered", out_valid, 1);
    send_row(SW'(100));
    send_row(SW'(200));
    send_row(SW'(300));
    clear = 1'b1;
    @(negedge clk);
    check("t5_ready_in_clear", in_ready, 0);
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("t5_kept_valid", out_valid, 1);
    check("t5_kept_sum", out_sum, 60);
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 20; i <= 24; i++) send_row(SW'(i));
    idle(20);
    check("t5_drained", exp_q.size(), 0);
    check("t5_fresh_sum", last_sum, 110);
    check("t5_busy", busy, 0);

    // Full-scale rows: no wrap in the 25-bit window sum
    for (int i = 0; i < 5; i++) send_row(22'h3FFFFF);
    idle(15);
    check("t6_max_sum", last_sum, 20971515);

    // Asynchronous reset with three rows in flight
    idle(1);
    send_row(SW'(1));
    send_row(SW'(2));
    send_row(SW'(3));
    #2 rst_b = 1'b0;
    @(negedge clk);
    check("t1_in_ready", in_ready, 1);
    check("t1_out_valid", out_valid, 0);
    check("t1_out_sum", out_sum, 0);
    check("t1_busy", busy, 0);
    @(posedge clk);
    #1 rst_b = 1'b1;
    ov_cyc_q.delete();
    idle(20);
    check("t1_no_window", ov_cyc_q.size(), 0);
    check("t1_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
